dna_port_responder: RTL and testbench
=====================================

// Module: dna_port_responder
// PURPOSE
//  Synthesizable single-clock emulation of the Spartan-6 DNA_PORT shift register: the responder end of
//  the READ/SHIFT/CLK/DIN -> DOUT serial ID protocol. Used on targets without DNA_PORT and as an RTL
//  stand-in so board_id_generator-style readers can be exercised against a bit-accurate peer.
//  Oversamples the slow DNA clock in the system clock domain and presents DOUT like the primitive.
// PARAMETERS
//  ID_WIDTH     57                    width of the identifier shift register
//  ID_VALUE     57'h12345678_9ABCDE   identifier loaded on READ
//  SYNC_STAGES  2                     synchronizer depth on dna_clk/dna_read/dna_shift/dna_din (>=2)
// PORTS
//  clock        in   1   system clock (44 MHz nominal)
//  reset        in   1   asynchronous, active-high reset
//  dna_clk      in   1   slow protocol clock from reader (asynchronous to clock)
//  dna_read     in   1   load ID_VALUE on next dna_clk rising edge
//  dna_shift    in   1   shift on next dna_clk rising edge (ignored while dna_read=1)
//  dna_din      in   1   serial bit shifted into LSB
//  dna_dout     out  1   current MSB of shift register
//  bit_count    out  6   bits shifted since last load, saturates at ID_WIDTH
//  readout_done out  1   1-cycle pulse when bit_count reaches ID_WIDTH
//  loaded       out  1   high once any load has occurred since reset
// BEHAVIOUR
//  - Reset (async assert, sync-consumed release): shreg=0, dna_dout=0, bit_count=0, readout_done=0,
//    loaded=0, all synchronizer and edge-detect flops 0 (so dna_clk high at release is not an edge).
//  - All four protocol inputs pass through identical SYNC_STAGES-deep flop chains; one extra flop on
//    synchronized dna_clk forms rise = s_clk & ~s_clk_d. read/shift/din are used from the same stage
//    as s_clk, so they are aligned with the edge they were set up for.
//  - Reader must hold dna_clk high and low >= SYNC_STAGES+1 clocks each and keep read/shift/din stable
//    across the edge; narrower pulses are unspecified.
//  - On rise (one cycle, registered):
//      read=1          : shreg <= ID_VALUE; bit_count <= 0; loaded <= 1.  READ wins over SHIFT.
//      read=0, shift=1 : shreg <= {shreg[ID_WIDTH-2:0], din}; bit_count <= sat(bit_count+1).
//      both 0          : hold.
//  - dna_dout = shreg[ID_WIDTH-1], registered; valid SYNC_STAGES+2 clocks after the dna_clk pad edge.
//    After a load dna_dout = ID_VALUE[56]; after k shifts = ID_VALUE[56-k] (k<57), then din history.
//  - Shift with loaded=0 is legal: shifts zeros/din, bit_count still advances.
//  - readout_done pulses on the rise cycle where bit_count goes ID_WIDTH-1 -> ID_WIDTH; further shifts
//    keep bit_count at ID_WIDTH (no wrap, no repeat pulse) until next load.
//  - Recirculation (din tied to dout): after ID_WIDTH shifts shreg == ID_VALUE again.
//  - Reset mid-readout: everything returns to reset values; reader must re-issue READ.
//  - FSM (2 states): EMPTY (loaded=0) -> LOADED on first READ edge; LOADED only exits via reset.
// STRUCTURE
//  - Shared package: DNA_ID_WIDTH=57, DNA_SIM_VALUE=57'h12345678_9ABCDE, bit_count width
//    $clog2(DNA_ID_WIDTH+1), so reader and responder agree.
//  - One sub-module: sync_bit_edge (SYNC_STAGES chain + rising-edge detect), instanced for dna_clk;
//    plain chains for read/shift/din. Remainder (shreg, counter, FSM) in top.
// TESTING
//  1 READ edge then 57 SHIFT edges, din=dout -> dout sequence = 0x123456789ABCDE MSB first; shreg ends
//    == ID_VALUE; readout_done single pulse on 57th shift; bit_count=57.
//  2 Connect board_id_generator (64x divider) -> its board_identifier == 32'h789ABCDE, ready=1.
//  3 read=1 and shift=1 on same edge -> load only: dout=ID_VALUE[56]=0, bit_count=0.
//  4 No READ, 3 shifts with din=1,0,1 -> bit_count=3, loaded=0, shreg[2:0]=3'b101, dout=0.
//  5 Reset asserted after 20 shifts, dna_clk held high across release -> all outputs 0, no spurious
//    edge; fresh READ+57 shifts reproduces case 1.
//  6 70 shifts after load -> bit_count stays 57, exactly one readout_done pulse.

Source files
------------

// File: rtl/dna_port_responder_pkg.sv
// Shared constants for DNA_PORT readers and responders so both ends agree on
// identifier width, simulation identifier value and bit counter width.
package dna_port_responder_pkg;

  localparam int              DNA_ID_WIDTH  = 57;
  localparam logic [56:0]     DNA_SIM_VALUE = 57'h12345678_9ABCDE;
  localparam int              DNA_CNT_WIDTH = $clog2(DNA_ID_WIDTH + 1);

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } dna_state_e;

endpackage

// File: rtl/dna_port_responder_sync_bit_edge.sv
// Synchronizer chain plus rising-edge detector for the slow DNA clock.
// A level already high when reset releases is never reported as an edge.
module sync_bit_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] fill_q;
  logic              prev_q;
  logic              armed_q;

  // fill_q marks when chain_q holds real samples; arming needs a genuine low first
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
      fill_q  <= {fill_q[STAGES-2:0], 1'b1};
      prev_q  <= chain_q[STAGES-1];
      armed_q <= armed_q | (fill_q[STAGES-1] & ~chain_q[STAGES-1]);
    end
  end

  assign rise_o = armed_q & chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/dna_port_responder.sv
// Single-clock emulation of the DNA_PORT identifier shift register, responding
// to an oversampled READ/SHIFT/CLK/DIN reader and presenting DOUT like the primitive.
module dna_port_responder
  import dna_port_responder_pkg::*;
#(
  parameter int                  ID_WIDTH    = DNA_ID_WIDTH,
  parameter logic [ID_WIDTH-1:0] ID_VALUE    = DNA_SIM_VALUE,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             dna_clk_i,
  input  logic                             dna_read_i,
  input  logic                             dna_shift_i,
  input  logic                             dna_din_i,
  output logic                             dna_dout_o,
  output logic [$clog2(ID_WIDTH+1)-1:0]    bit_count_o,
  output logic                             readout_done_o,
  output logic                             loaded_o
);

  localparam int                CW      = $clog2(ID_WIDTH + 1);
  localparam logic [CW-1:0]     CNT_MAX = CW'(ID_WIDTH);

  logic [2:0] ctl_in;
  logic [2:0] ctl_s;
  logic       rise;

  assign ctl_in = {dna_din_i, dna_shift_i, dna_read_i};

  sync_bit_edge #(.STAGES(SYNC_STAGES)) u_clk_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (dna_clk_i),
    .rise_o (rise)
  );

  // Same depth as the clock chain so read/shift/din line up with the detected edge
  for (genvar gi = 0; gi < 3; gi++) begin : g_ctl_sync
    logic [SYNC_STAGES-1:0] chain_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) chain_q <= '0;
      else       chain_q <= {chain_q[SYNC_STAGES-2:0], ctl_in[gi]};
    end
    assign ctl_s[gi] = chain_q[SYNC_STAGES-1];
  end

  dna_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                dout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dout_q  <= shreg_q[ID_WIDTH-1];
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (rise) begin
      if (ctl_s[0]) begin
        shreg_d = ID_VALUE;
        cnt_d   = '0;
        state_d = ST_LOADED;
      end else if (ctl_s[1]) begin
        shreg_d = {shreg_q[ID_WIDTH-2:0], ctl_s[2]};
        // Saturate at full width; the done pulse fires only on the final step
        if (cnt_q != CNT_MAX) begin
          cnt_d  = cnt_q + 1'b1;
          done_d = (cnt_q == CNT_MAX - 1'b1);
        end
      end
    end
  end

  assign dna_dout_o     = dout_q;
  assign bit_count_o    = cnt_q;
  assign readout_done_o = done_q;
  assign loaded_o       = (state_q == ST_LOADED);

endmodule

// File: tb/tb_dna_port_responder.sv
// Drives DNA_PORT protocol edges (directed + random) and compares the responder
// against a behavioural identifier-register model.
module tb_dna_port_responder;
  import dna_port_responder_pkg::*;

  localparam int          W   = DNA_ID_WIDTH;
  localparam logic [56:0] IDV = 57'h12345678_9ABCDE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dclk = 1'b0, dread = 1'b0, dshift = 1'b0, ddin = 1'b0;
  logic       dout, done, loaded;
  logic [5:0] bcnt;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  logic [W-1:0] m_sh;
  int           m_cnt;
  logic         m_loaded;
  int           m_done;
  logic [W-1:0] seq;

  dna_port_responder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .dna_clk_i      (dclk),
    .dna_read_i     (dread),
    .dna_shift_i    (dshift),
    .dna_din_i      (ddin),
    .dna_dout_o     (dout),
    .bit_count_o    (bcnt),
    .readout_done_o (done),
    .loaded_o       (loaded)
  );

  always #5 clk = ~clk;

  // Counts high cycles, so a stretched or repeated pulse is visible
  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_dout"}, 64'(dout), 64'(m_sh[W-1]));
    check_val({tag, "_cnt"}, 64'(bcnt), 64'(m_cnt));
    check_val({tag, "_loaded"}, 64'(loaded), 64'(m_loaded));
    check_val({tag, "_done"}, 64'(done_seen), 64'(m_done));
  endtask

  task automatic dna_edge(input logic rd, input logic sh, input logic din, input string tag);
    dread = rd; dshift = sh; ddin = din;
    wait_clks(4);
    dclk = 1'b1;
    wait_clks(6);
    if (rd) begin
      m_sh = IDV; m_cnt = 0; m_loaded = 1'b1;
    end else if (sh) begin
      m_sh = {m_sh[W-2:0], din};
      if (m_cnt < W) begin
        m_cnt++;
        if (m_cnt == W) m_done++;
      end
    end
    check_state(tag);
    $display("edge %s rd=%0d sh=%0d din=%0d dout=%0d cnt=%0d loaded=%0d", tag, rd, sh, din, dout, bcnt, loaded);
    dclk = 1'b0;
    wait_clks(4);
  endtask

  task automatic do_reset(input logic clk_high, input string tag);
    dread = 1'b0; dshift = 1'b1; ddin = 1'b1;
    wait_clks(1);
    rst = 1'b1;
    if (clk_high) dclk = 1'b1;
    wait_clks(3);
    check_val({tag, "_in_rst_dout"}, 64'(dout), 64'd0);
    check_val({tag, "_in_rst_cnt"}, 64'(bcnt), 64'd0);
    check_val({tag, "_in_rst_loaded"}, 64'(loaded), 64'd0);
    rst = 1'b0;
    wait_clks(8);
    m_sh = '0; m_cnt = 0; m_loaded = 1'b0;
    check_state({tag, "_post_rst"});
    $display("reset %s clk_high=%0d dout=%0d cnt=%0d loaded=%0d", tag, clk_high, dout, bcnt, loaded);
    dclk = 1'b0;
    wait_clks(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic rd, sh, din;
    m_sh = '0; m_cnt = 0; m_loaded = 1'b0; m_done = 0;
    wait_clks(3);
    check_state("reset_hold");
    rst = 1'b0;
    wait_clks(6);
    check_state("reset_rel");

    // Load then recirculate the full identifier
    dna_edge(1'b1, 1'b0, 1'b0, "t1_load");
    seq[W-1] = dout;
    for (int k = 1; k <= W; k++) begin
      dna_edge(1'b0, 1'b1, m_sh[W-1], "t1_shift");
      if (k < W) seq[W-1-k] = dout;
    end
    check_val("t1_seq_hi", 64'(seq[56:32]), 64'(IDV[56:32]));
    check_val("t1_seq_lo", 64'(seq[31:0]), 64'(IDV[31:0]));
    check_val("t1_recirc_dout", 64'(dout), 64'(IDV[56]));
    check_val("t1_cnt57", 64'(bcnt), 64'd57);

    // Read and shift together: load wins
    dna_edge(1'b0, 1'b1, 1'b1, "t3_pre");
    dna_edge(1'b1, 1'b1, 1'b1, "t3_rd_sh");
    check_val("t3_cnt0", 64'(bcnt), 64'd0);

    // Shifts without any load
    do_reset(1'b0, "t4");
    dna_edge(1'b0, 1'b1, 1'b1, "t4_a");
    dna_edge(1'b0, 1'b1, 1'b0, "t4_b");
    dna_edge(1'b0, 1'b1, 1'b1, "t4_c");
    check_val("t4_cnt3", 64'(bcnt), 64'd3);
    for (int k = 0; k < 54; k++) dna_edge(1'b0, 1'b1, 1'b0, "t4_fill");
    check_val("t4_first_bit_out", 64'(dout), 64'd1);

    // Reset mid-readout with dna_clk high across release
    dna_edge(1'b1, 1'b0, 1'b0, "t5_load");
    for (int k = 0; k < 20; k++) dna_edge(1'b0, 1'b1, m_sh[W-1], "t5_shift");
    do_reset(1'b1, "t5");
    dna_edge(1'b1, 1'b0, 1'b0, "t5_reload");
    for (int k = 0; k < W; k++) dna_edge(1'b0, 1'b1, m_sh[W-1], "t5_reshift");

    // Over-shift: saturation and a single done pulse
    dna_edge(1'b1, 1'b0, 1'b0, "t6_load");
    for (int k = 0; k < 70; k++) dna_edge(1'b0, 1'b1, 1'($urandom_range(0, 1)), "t6_shift");
    check_val("t6_cnt_sat", 64'(bcnt), 64'd57);

    // Random protocol traffic, including idle edges
    for (int k = 0; k < 150; k++) begin
      rd  = ($urandom_range(0, 15) == 0);
      sh  = ($urandom_range(0, 3) != 0);
      din = 1'($urandom_range(0, 1));
      dna_edge(rd, sh, din, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
